// File: rtl/aim65_dma_pkg.sv
// Shared constants for the AIM65 RAM DMA engine: operation modes and FSM state encoding.
package aim65_dma_pkg;

    localparam logic [1:0] MODE_LOAD = 2'b00;
    localparam logic [1:0] MODE_FILL = 2'b01;
    localparam logic [1:0] MODE_DUMP = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLoad   = 3'd1,
        StFill   = 3'd2,
        StRdAddr = 3'd3,
        StRdCap  = 3'd4,
        StRdOut  = 3'd5,
        StDone   = 3'd6
    } dma_state_e;

endpackage

// File: rtl/ram_dma.sv
// RAM bus initiator: streams bytes into RAM (LOAD), writes a constant (FILL) or streams a
// contiguous range back out (DUMP). Drives the RAM port only while busy.
module ram_dma
    import aim65_dma_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  ram_cs,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_rw,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam logic [ADDR_WIDTH:0] LastCnt = {{ADDR_WIDTH{1'b0}}, 1'b1};

    dma_state_e            state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   remain_q;
    logic [DATA_WIDTH-1:0] fill_q;
    logic [DATA_WIDTH-1:0] m_data_q;
    logic                  m_valid_q;
    logic                  wr_en;
    logic                  rd_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            remain_q  <= '0;
            fill_q    <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        addr_q   <= base_addr;
                        remain_q <= length;
                        fill_q   <= fill_value;
                        if (length == '0) begin
                            state_q <= StDone;
                        end else begin
                            case (mode)
                                MODE_LOAD: state_q <= StLoad;
                                MODE_FILL: state_q <= StFill;
                                MODE_DUMP: state_q <= StRdAddr;
                                MODE_RSVD: state_q <= StDone;
                            endcase
                        end
                    end
                end
                StLoad: begin
                    if (s_valid) begin
                        addr_q   <= addr_q + 1'b1;
                        remain_q <= remain_q - 1'b1;
                        if (remain_q == LastCnt) state_q <= StDone;
                    end
                end
                StFill: begin
                    addr_q   <= addr_q + 1'b1;
                    remain_q <= remain_q - 1'b1;
                    if (remain_q == LastCnt) state_q <= StDone;
                end
                StRdAddr: state_q <= StRdCap;
                StRdCap: begin
                    // RAM output is registered, so the byte addressed in RD_ADDR is valid now
                    m_data_q  <= ram_rdata;
                    m_valid_q <= 1'b1;
                    addr_q    <= addr_q + 1'b1;
                    remain_q  <= remain_q - 1'b1;
                    state_q   <= StRdOut;
                end
                StRdOut: begin
                    if (m_valid_q && m_ready) begin
                        m_valid_q <= 1'b0;
                        state_q   <= (remain_q != '0) ? StRdAddr : StDone;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wr_en = ((state_q == StLoad) && s_valid) || (state_q == StFill);
    assign rd_en = (state_q == StRdAddr);

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign s_ready  = (state_q == StLoad);
    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign ram_cs   = wr_en || rd_en;
    assign ram_rw   = ~wr_en;
    assign ram_addr = addr_q;

    always_comb begin
        ram_wdata = '0;
        if (state_q == StLoad) begin
            ram_wdata = s_data;
        end else if (state_q == StFill) begin
            ram_wdata = fill_q;
        end
    end

endmodule

// File: tb/tb_ram_dma.sv
// Bench for ram_dma: behavioural RAM plus a reference memory image and per-scenario checks.
module tb_ram_dma;
    import aim65_dma_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] base_addr = '0;
    logic [16:0] length = '0;
    logic [7:0]  fill_value = '0;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        m_ready = 1'b0;
    logic        busy, done, s_ready, m_valid, ram_cs, ram_rw;
    logic [7:0]  m_data, ram_wdata;
    logic [7:0]  ram_rdata = '0;
    logic [15:0] ram_addr;

    ram_dma dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .base_addr(base_addr),
        .length(length), .fill_value(fill_value), .busy(busy), .done(done),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .ram_cs(ram_cs), .ram_addr(ram_addr), .ram_rw(ram_rw),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [15:0] wa[$];
    logic [7:0]  wd[$];
    int          wc[$];
    int          cyc = 0, rd_cnt = 0, done_cnt = 0, cs_cnt = 0;
    int          n_cmp = 0, n_err = 0;
    logic [7:0]  ld_data[$];
    bit          ld_valid[$];
    logic [7:0]  got[$];

    // Behavioural single-port RAM with registered read data, plus activity log
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_cs && !ram_rw) begin
            mem[ram_addr] <= ram_wdata;
            wa.push_back(ram_addr);
            wd.push_back(ram_wdata);
            wc.push_back(cyc);
        end
        if (ram_cs && ram_rw) begin
            ram_rdata <= mem[ram_addr];
            rd_cnt    <= rd_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (ram_cs) cs_cnt <= cs_cnt + 1;
    end

    task automatic pulse_start(input logic [1:0] md, input logic [15:0] b, input logic [16:0] l,
                               input logic [7:0] f);
        @(posedge clk); #1;
        start = 1'b1; mode = md; base_addr = b; length = l; fill_value = f;
        @(posedge clk); #1;
        start = 1'b0; mode = 2'($urandom); base_addr = 16'($urandom);
        length = 17'($urandom); fill_value = 8'($urandom);
    endtask

    task automatic drive_load();
        int idx = 0;
        int k = 0;
        bit v;
        while (idx < ld_data.size()) begin
            v = (k < ld_valid.size()) ? ld_valid[k] : 1'b1;
            k++;
            s_valid = v;
            s_data  = v ? ld_data[idx] : 8'($urandom);
            @(posedge clk); #1;
            if (v) idx++;
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
        m_ready = 1'b0;
    endtask

    // Stream consumer; holds off byte stall_idx for stall_len cycles and checks it meanwhile
    task automatic consume(input int n, input int stall_idx, input int stall_len, input bit rnd);
        int         stalled = 0;
        int         rd_snap = 0;
        logic [7:0] held = '0;
        got.delete();
        for (int c = 0; c < n * 20 + 50 && got.size() < n; c++) begin
            @(negedge clk);
            if (!m_valid) begin
                m_ready = 1'b0;
            end else if (got.size() == stall_idx && stalled < stall_len) begin
                m_ready = 1'b0;
                if (stalled == 0) begin
                    held = m_data; rd_snap = rd_cnt;
                end else begin
                    n_cmp++;
                    if (m_data !== held) begin
                        n_err++; $display("FAIL dump_stall_data: got %h want %h", m_data, held);
                    end
                end
                stalled++;
                if (stalled == stall_len) begin
                    n_cmp++;
                    if (rd_cnt !== rd_snap) begin
                        n_err++; $display("FAIL dump_stall_reads: got %0d want %0d", rd_cnt, rd_snap);
                    end
                end
            end else if (rnd && $urandom_range(0, 2) == 0) begin
                m_ready = 1'b0;
            end else begin
                got.push_back(m_data);
                m_ready = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp += 9;
        if (busy !== 1'b0)       begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (done !== 1'b0)       begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
        if (s_ready !== 1'b0)    begin n_err++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
        if (m_valid !== 1'b0)    begin n_err++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        if (m_data !== 8'h00)    begin n_err++; $display("FAIL rst_m_data: got %h want 00", m_data); end
        if (ram_cs !== 1'b0)     begin n_err++; $display("FAIL rst_cs: got %b want 0", ram_cs); end
        if (ram_rw !== 1'b1)     begin n_err++; $display("FAIL rst_rw: got %b want 1", ram_rw); end
        if (ram_addr !== 16'h0)  begin n_err++; $display("FAIL rst_addr: got %h want 0", ram_addr); end
        if (ram_wdata !== 8'h00) begin n_err++; $display("FAIL rst_wdata: got %h want 0", ram_wdata); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || ram_cs !== 1'b0) begin
            n_err++; $display("FAIL idle_after_rst: busy %b cs %b want 0 0", busy, ram_cs);
        end
    endtask

    task automatic test_load();
        bit ok;
        int d0 = done_cnt;
        ld_data = {8'h11, 8'h22, 8'h33, 8'h44};
        ld_valid = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        wa.delete(); wd.delete();
        pulse_start(MODE_LOAD, 16'h0200, 17'd4, 8'h00);
        drive_load();
        wait_done(20, ok);
        repeat (2) @(negedge clk);
        n_cmp += 4;
        if (!ok)             begin n_err++; $display("FAIL load_done: got timeout want done"); end
        if (wa.size() != 4)  begin n_err++; $display("FAIL load_writes: got %0d want 4", wa.size()); end
        if (done_cnt - d0 != 1) begin n_err++; $display("FAIL load_done_cnt: got %0d want 1", done_cnt - d0); end
        if (busy !== 1'b0)   begin n_err++; $display("FAIL load_busy: got %b want 0", busy); end
        for (int i = 0; i < 4 && i < wa.size(); i++) begin
            n_cmp++;
            if (wa[i] !== 16'h0200 + 16'(i) || wd[i] !== ld_data[i]) begin
                n_err++; $display("FAIL load_wr%0d: got %h=%h want %h=%h", i, wa[i], wd[i],
                                  16'h0200 + 16'(i), ld_data[i]);
            end
            ref_mem[16'h0200 + 16'(i)] = ld_data[i];
        end
    endtask

    task automatic test_fill();
        bit ok;
        wa.delete(); wd.delete(); wc.delete();
        pulse_start(MODE_FILL, 16'h0000, 17'd256, 8'hA5);
        wait_done(300, ok);
        @(negedge clk);
        n_cmp += 3;
        if (!ok)              begin n_err++; $display("FAIL fill_done: got timeout want done"); end
        if (wa.size() != 256) begin n_err++; $display("FAIL fill_writes: got %0d want 256", wa.size()); end
        if (wc.size() == 256 && wc[255] - wc[0] != 255) begin
            n_err++; $display("FAIL fill_span: got %0d want 255", wc[255] - wc[0]);
        end
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'hA5;
        for (int i = 0; i < 256 && i < wa.size(); i += 51) begin
            n_cmp++;
            if (wa[i] !== 16'(i) || wd[i] !== 8'hA5) begin
                n_err++; $display("FAIL fill_wr%0d: got %h=%h want %h=a5", i, wa[i], wd[i], 16'(i));
            end
        end
        n_cmp++;
        if (mem[16'h0100] !== 8'hFF) begin
            n_err++; $display("FAIL fill_beyond: got %h want ff", mem[16'h0100]);
        end
    endtask

    task automatic test_dump();
        bit ok;
        int r0 = rd_cnt;
        wa.delete();
        pulse_start(MODE_DUMP, 16'h0200, 17'd4, 8'h00);
        consume(4, 2, 5, 1'b0);
        wait_done(10, ok);
        n_cmp += 3;
        if (!ok)            begin n_err++; $display("FAIL dump_done: got timeout want done"); end
        if (got.size() != 4) begin n_err++; $display("FAIL dump_count: got %0d want 4", got.size()); end
        if (rd_cnt - r0 != 4) begin n_err++; $display("FAIL dump_reads: got %0d want 4", rd_cnt - r0); end
        for (int i = 0; i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== 8'h11 * 8'(i + 1)) begin
                n_err++; $display("FAIL dump_byte%0d: got %h want %h", i, got[i], 8'h11 * 8'(i + 1));
            end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        ld_data.delete(); ld_valid.delete();
        for (int i = 0; i < 4; i++) ld_data.push_back(8'($urandom));
        wa.delete(); wd.delete();
        pulse_start(MODE_LOAD, 16'hFFFE, 17'd4, 8'h00);
        drive_load();
        wait_done(10, ok);
        n_cmp += 2;
        if (!ok)            begin n_err++; $display("FAIL wrap_done: got timeout want done"); end
        if (wa.size() != 4) begin n_err++; $display("FAIL wrap_writes: got %0d want 4", wa.size()); end
        for (int i = 0; i < 4 && i < wa.size(); i++) begin
            n_cmp++;
            if (wa[i] !== 16'hFFFE + 16'(i) || wd[i] !== ld_data[i]) begin
                n_err++; $display("FAIL wrap_wr%0d: got %h=%h want %h=%h", i, wa[i], wd[i],
                                  16'hFFFE + 16'(i), ld_data[i]);
            end
            ref_mem[16'hFFFE + 16'(i)] = ld_data[i];
        end
    endtask

    task automatic test_zero_and_busy();
        bit ok;
        int c0 = cs_cnt;
        int d0;
        for (int t = 0; t < 2; t++) begin
            if (t == 0) pulse_start(MODE_LOAD, 16'($urandom), 17'd0, 8'($urandom));
            else        pulse_start(MODE_RSVD, 16'($urandom), 17'($urandom_range(1, 99)), 8'h00);
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b1) begin n_err++; $display("FAIL noop%0d_done: got %b want 1", t, done); end
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++; $display("FAIL noop%0d_idle: done %b busy %b want 0 0", t, done, busy);
            end
        end
        n_cmp++;
        if (cs_cnt != c0) begin n_err++; $display("FAIL noop_cs: got %0d want %0d", cs_cnt, c0); end
        wa.delete(); wd.delete();
        c0 = rd_cnt; d0 = done_cnt;
        pulse_start(MODE_FILL, 16'h3000, 17'd8, 8'h5A);
        pulse_start(MODE_DUMP, 16'h4000, 17'd2, 8'h77);
        wait_done(20, ok);
        repeat (4) @(negedge clk);
        n_cmp += 5;
        if (!ok)             begin n_err++; $display("FAIL busy_done: got timeout want done"); end
        if (wa.size() != 8)  begin n_err++; $display("FAIL busy_writes: got %0d want 8", wa.size()); end
        if (rd_cnt != c0)    begin n_err++; $display("FAIL busy_reads: got %0d want %0d", rd_cnt, c0); end
        if (done_cnt - d0 != 1) begin n_err++; $display("FAIL busy_done_cnt: got %0d want 1", done_cnt - d0); end
        if (busy !== 1'b0)   begin n_err++; $display("FAIL busy_idle: got %b want 0", busy); end
        for (int i = 0; i < 8 && i < wa.size(); i++) begin
            n_cmp++;
            if (wa[i] !== 16'h3000 + 16'(i) || wd[i] !== 8'h5A) begin
                n_err++; $display("FAIL busy_wr%0d: got %h=%h want %h=5a", i, wa[i], wd[i],
                                  16'h3000 + 16'(i));
            end
            ref_mem[16'h3000 + 16'(i)] = 8'h5A;
        end
    endtask

    task automatic test_reset_mid_fill();
        bit ok;
        int d0 = done_cnt;
        wa.delete(); wd.delete();
        pulse_start(MODE_FILL, 16'h1000, 17'd64, 8'hC3);
        for (int i = 0; i < 40 && wa.size() < 9; i++) begin
            @(posedge clk); #1;
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || ram_cs !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL rst_async: busy %b cs %b done %b want 0 0 0", busy, ram_cs, done);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp += 2;
        if (wa.size() != 9)  begin n_err++; $display("FAIL rst_writes: got %0d want 9", wa.size()); end
        if (done_cnt != d0)  begin n_err++; $display("FAIL rst_no_done: got %0d want %0d", done_cnt, d0); end
        for (int i = 0; i < 9; i++) ref_mem[16'h1000 + 16'(i)] = 8'hC3;
        ld_data = {8'h5E, 8'h6F, 8'h70};
        ld_valid.delete();
        wa.delete(); wd.delete();
        pulse_start(MODE_LOAD, 16'h1004, 17'd3, 8'h00);
        drive_load();
        wait_done(10, ok);
        n_cmp += 2;
        if (!ok)            begin n_err++; $display("FAIL post_rst_done: got timeout want done"); end
        if (wa.size() != 3) begin n_err++; $display("FAIL post_rst_writes: got %0d want 3", wa.size()); end
        for (int i = 0; i < 3 && i < wa.size(); i++) begin
            n_cmp++;
            if (wa[i] !== 16'h1004 + 16'(i) || wd[i] !== ld_data[i]) begin
                n_err++; $display("FAIL post_rst_wr%0d: got %h=%h want %h=%h", i, wa[i], wd[i],
                                  16'h1004 + 16'(i), ld_data[i]);
            end
            ref_mem[16'h1004 + 16'(i)] = ld_data[i];
        end
    endtask

    task automatic test_random();
        bit          ok;
        int          md, l, r0;
        logic [15:0] b, a;
        logic [7:0]  f;
        for (int it = 0; it < 12; it++) begin
            md = $urandom_range(0, 2);
            b  = 16'($urandom);
            l  = $urandom_range(1, 24);
            f  = 8'($urandom);
            wa.delete(); wd.delete();
            r0 = rd_cnt;
            ld_data.delete(); ld_valid.delete();
            if (md == 0) begin
                for (int i = 0; i < l; i++) ld_data.push_back(8'($urandom));
                for (int i = 0; i < 2 * l; i++) ld_valid.push_back($urandom_range(0, 3) != 0);
                pulse_start(MODE_LOAD, b, 17'(l), f);
                drive_load();
            end else if (md == 1) begin
                for (int i = 0; i < l; i++) ld_data.push_back(f);
                pulse_start(MODE_FILL, b, 17'(l), f);
            end else begin
                pulse_start(MODE_DUMP, b, 17'(l), f);
                consume(l, $urandom_range(0, l - 1), $urandom_range(0, 3), 1'b1);
            end
            wait_done(40 * l + 20, ok);
            n_cmp += 2;
            if (!ok) begin n_err++; $display("FAIL rnd%0d_done: got timeout want done", it); end
            if (md == 2) begin
                if (got.size() != l || wa.size() != 0 || rd_cnt - r0 != l) begin
                    n_err++; $display("FAIL rnd%0d_dump_counts: got %0d/%0d/%0d want %0d/0/%0d",
                                      it, got.size(), wa.size(), rd_cnt - r0, l, l);
                end
                for (int i = 0; i < got.size(); i++) begin
                    a = b + 16'(i);
                    n_cmp++;
                    if (got[i] !== ref_mem[a]) begin
                        n_err++; $display("FAIL rnd%0d_dump%0d: got %h want %h", it, i, got[i], ref_mem[a]);
                    end
                end
            end else begin
                if (wa.size() != l || rd_cnt != r0) begin
                    n_err++; $display("FAIL rnd%0d_wr_counts: got %0d/%0d want %0d/0",
                                      it, wa.size(), rd_cnt - r0, l);
                end
                for (int i = 0; i < l; i++) begin
                    a = b + 16'(i);
                    ref_mem[a] = ld_data[i];
                    if (i < wa.size()) begin
                        n_cmp++;
                        if (wa[i] !== a || wd[i] !== ld_data[i]) begin
                            n_err++; $display("FAIL rnd%0d_wr%0d: got %h=%h want %h=%h",
                                              it, i, wa[i], wd[i], a, ld_data[i]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_mem_image();
        int bad = 0;
        for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) bad++;
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL mem_image: got %0d differing bytes want 0", bad); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'hFF;
            ref_mem[i] = 8'hFF;
        end
        test_reset();
        test_load();
        test_fill();
        test_dump();
        test_wrap();
        test_zero_and_busy();
        test_reset_mid_fill();
        test_random();
        test_mem_image();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_dma.md
Name: ram_dma

Overview:
- Bus initiator that drives the single-port synchronous `ram` block (cs / addr / rw / data_in / data_out) on behalf of the host-side loader.
- Three operations over a contiguous byte range:
  - LOAD: write an incoming byte stream into RAM.
  - FILL: write a constant value over the range.
  - DUMP: read the range back out as a byte stream.
- Sits between the MiSTer ioctl/monitor logic and the AIM65 RAM mux. It owns the RAM port only while busy=1.

Parameters:
- ADDR_WIDTH, 16, width of ram_addr and base_addr. Address arithmetic is modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 8, RAM data width and stream data width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle request, sampled only in IDLE.
- mode  in  2  operation: 00 LOAD, 01 FILL, 10 DUMP, 11 reserved. Latched at start.
- base_addr  in  ADDR_WIDTH  first RAM address, latched at start.
- length  in  ADDR_WIDTH+1  byte count, 0..2^ADDR_WIDTH, latched at start.
- fill_value  in  DATA_WIDTH  FILL constant, latched at start.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  one-cycle completion pulse.
- s_data  in  DATA_WIDTH  LOAD stream data.
- s_valid  in  1  LOAD stream valid.
- s_ready  out  1  LOAD stream ready.
- m_data  out  DATA_WIDTH  DUMP stream data, registered.
- m_valid  out  1  DUMP stream valid, registered.
- m_ready  in  1  DUMP stream ready.
- ram_cs  out  1  to ram.cs.
- ram_addr  out  ADDR_WIDTH  to ram.addr.
- ram_rw  out  1  to ram.rw; 1 = read, 0 = write.
- ram_wdata  out  DATA_WIDTH  to ram.data_in.
- ram_rdata  in  DATA_WIDTH  from ram.data_out. The RAM registers this output, so it is valid one cycle after the address is presented.

Behaviour:
- Reset values:
  - outputs: busy=0, done=0, s_ready=0, m_valid=0, m_data=0, ram_cs=0, ram_rw=1, ram_addr=0, ram_wdata=0.
  - internal: state=IDLE, address counter=0, remaining count=0.
- States: IDLE, LOAD, FILL, RD_ADDR, RD_CAP, RD_OUT, DONE.
- IDLE:
  - start=1 latches mode, base_addr, length and fill_value. The address counter takes base_addr and the remaining count takes length.
  - Next state:
    - length=0 or mode=11 -> DONE, with no RAM access.
    - Otherwise LOAD, FILL or RD_ADDR according to mode.
  - start while not in IDLE is ignored.
- LOAD:
  - s_ready=1.
  - On s_valid=1 in the same cycle: ram_cs=1, ram_rw=0, ram_wdata=s_data, ram_addr=counter. These are combinational from s_valid and the state.
  - At the edge: counter+1 (wraps), remaining-1. Remaining reaching 0 -> DONE.
  - s_valid=0: no access and no stall limit.
- FILL:
  - One write per cycle: ram_cs=1, ram_rw=0, ram_wdata=fill_value.
  - Counter and remaining step every cycle. Remaining reaching 0 -> DONE.
- RD_ADDR: ram_cs=1, ram_rw=1, ram_addr=counter. Next state RD_CAP.
- RD_CAP: m_data<=ram_rdata, m_valid<=1, counter+1, remaining-1. Next state RD_OUT.
- RD_OUT:
  - Hold m_data and m_valid until m_valid & m_ready.
  - On that handshake, m_valid<=0, then RD_ADDR if remaining>0, else DONE.
  - DUMP throughput: 1 byte per 3 cycles minimum.
- DONE: done=1 for exactly one cycle, busy=0 from the next cycle, return to IDLE. A new start is accepted in the following IDLE cycle.
- Outside write cycles:
  - ram_cs=0 except in FILL, RD_ADDR, and LOAD with s_valid=1.
  - ram_rw=1.
  - ram_addr keeps tracking the counter.
- Length boundaries:
  - length=2^ADDR_WIDTH covers the full address space exactly once.
  - The counter wraps from all-ones to 0 with no error.
- Reset mid-operation:
  - Immediate return to IDLE with no done pulse.
  - Writes in flight at the asserting edge are not guaranteed; writes after reset are forbidden.
- RAM port access rules:
  - No read-modify-write.
  - The RAM is never written and read in the same cycle by this block.

Decomposition:
- Package aim65_dma_pkg:
  - mode constants MODE_LOAD=2'b00, MODE_FILL=2'b01, MODE_DUMP=2'b10, MODE_RSVD=2'b11.
  - state encoding constants.
- No sub-module. The counter and remaining logic are inline; splitting them out adds ports without reuse.

Test Plan:
- LOAD with base=16'h0200, length=4, s_data 11,22,33,44, s_valid toggled 1,0,1,1,1 -> RAM[0200..0203]=11,22,33,44, exactly 4 write cycles, done pulses once, busy low afterwards.
- FILL with base=16'h0000, length=256, fill_value=A5 -> writes occupy 256 consecutive cycles, RAM[0000..00FF]=A5, RAM[0100] unchanged (FF).
- DUMP of the LOAD region, with m_ready stalled 5 cycles on byte 2 -> stream 11,22,33,44; m_data stable during the stall; no extra RAM reads issued during the stall.
- Wrap: LOAD at base=16'hFFFE, length=4 -> addresses FFFE, FFFF, 0000, 0001 written in that order.
- length=0 and mode=11 -> done one cycle after start, ram_cs never asserted; a start pulse while busy is ignored, with no latch change.
- Reset asserted mid-FILL, at the 10th byte -> busy, ram_cs and done go 0 asynchronously; no further RAM writes; the next start works normally.
